// File: rtl/uart_pkg.sv
// uart_pkg: shared FIFO/data-width defaults and tx_feeder state encoding
package uart_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2} feeder_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with wrapping pointers, occupancy count and flush
module sync_fifo import uart_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                     bclk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];
  // storage array carries no reset; only accepted writes land
  always_ff @(posedge bclk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at DEPTH; flush returns everything to the origin
  always_ff @(posedge bclk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
endmodule

// File: rtl/tx_feeder.sv
// tx_feeder: queues bytes and launches one TX frame at a time with a start pulse
module tx_feeder import uart_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                     bclk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     ovf_clr,
  input  logic                     tx_done,
  output logic                     tx_en,
  output logic [DW-1:0]            din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy
);
  feeder_state_t state, state_nxt;
  logic arm, elig, pop;
  logic [DW-1:0] head;
  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .bclk(bclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop), .flush(flush),
    .rd_data(head), .full(full), .empty(empty), .count(count)
  );
  assign elig = (state == IDLE) & enable & ~empty & ~flush;
  assign pop = elig & arm;
  assign tx_en = state == LAUNCH;
  assign busy = state != IDLE;
  // next state: pop launches, LAUNCH lasts one cycle, WAIT ends on tx_done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // the first eligible idle cycle arms, the second pops; this sets the two-cycle launch latency
  always_ff @(posedge bclk or posedge rst)
    if (rst) begin
      state <= IDLE;
      arm <= 1'b0;
      din <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      arm <= elig & ~arm;
      din <= pop ? head : din;
      overflow <= (wr_en & full) | (overflow & ~ovf_clr);
    end
endmodule

// File: tb/tb_tx_feeder.sv
// tb_tx_feeder: table vectors, directed sequences and random traffic against a queue model
module tb_tx_feeder;
  localparam int DEPTH = 16;
  localparam int DW = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  logic bclk = 1'b0, rst = 1'b0, wr_en = 1'b0, enable = 1'b0, flush = 1'b0, ovf_clr = 1'b0, tx_done = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic tx_en, full, empty, overflow, busy;
  logic [DW-1:0] din;
  logic [CW-1:0] count;
  tx_feeder #(.DEPTH(DEPTH), .DW(DW)) dut (
    .bclk(bclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .enable(enable), .flush(flush),
    .ovf_clr(ovf_clr), .tx_done(tx_done), .tx_en(tx_en), .din(din), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .busy(busy)
  );
  always #5 bclk = ~bclk;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] sent[$];
  logic [DW-1:0] m_din;
  logic m_ovf, m_busy, m_txen;
  int m_ready;
  typedef struct {
    logic wr; logic [7:0] d; logic en, fl, oc, td;
    logic txen, bsy; logic [4:0] cnt; logic [7:0] dout; logic ovf;
  } vec_t;
  vec_t tv[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_din = '0;
    m_ovf = 1'b0;
    m_busy = 1'b0;
    m_txen = 1'b0;
    m_ready = 0;
  endtask
  // a frame starts on the second consecutive idle cycle in which a pop is allowed
  task automatic model_edge();
    bit ok, pop, was_full;
    ok = !m_busy && enable && q.size() > 0 && !flush;
    pop = ok && m_ready == 1;
    was_full = q.size() == DEPTH;
    if (wr_en && was_full) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (flush) q.delete();
    else begin
      if (pop) m_din = q.pop_front();
      if (wr_en && !was_full) q.push_back(wr_data);
    end
    if (m_txen) m_txen = 1'b0;
    else if (m_busy && tx_done) m_busy = 1'b0;
    if (pop) begin
      m_txen = 1'b1;
      m_busy = 1'b1;
    end
    m_ready = (ok && !pop) ? 1 : 0;
  endtask
  task automatic cmp_model();
    chk("tx_en", tx_en, m_txen);
    chk("busy", busy, m_busy);
    chk("din", din, m_din);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
  endtask
  task automatic step();
    @(posedge bclk);
    if (rst) model_reset();
    else model_edge();
    #1;
    cmp_model();
    if (tx_en) sent.push_back(din);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0; enable = 1'b0; flush = 1'b0; ovf_clr = 1'b0; tx_done = 1'b0; wr_data = '0;
    #1;
    model_reset();
    cmp_model();
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic wait_txen(input int budget, output int cyc);
    cyc = 0;
    while (!tx_en && cyc < budget) begin
      step();
      cyc++;
    end
    chk("txen_wait", tx_en, 1);
  endtask
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  initial begin
    int n, cyc, base, nxt;
    tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0};
    tv[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0};
    tv[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 8'hA5, 1'b0};
    tv[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'hA5, 1'b0};
    tv[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 1'b0};
    tv[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b0};
    tv[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b0};
    tv[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b0};
    tv[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'hA5, 1'b0};
    tv[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'hA5, 1'b0};
    #2;
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    for (int i = 0; i < 10; i++) begin
      wr_en = tv[i].wr; wr_data = tv[i].d; enable = tv[i].en;
      flush = tv[i].fl; ovf_clr = tv[i].oc; tx_done = tv[i].td;
      step();
      chk("tv_txen", tx_en, tv[i].txen);
      chk("tv_busy", busy, tv[i].bsy);
      chk("tv_count", count, tv[i].cnt);
      chk("tv_din", din, tv[i].dout);
      chk("tv_ovf", overflow, tv[i].ovf);
    end
    // single frame, then a stalled controller
    do_reset();
    enable = 1'b1;
    wr(8'hA5);
    step();
    chk("lat_k1_txen", tx_en, 0);
    step();
    chk("lat_k2_txen", tx_en, 1);
    chk("lat_din", din, 8'hA5);
    n = 0;
    repeat (20) begin
      step();
      if (tx_en) n++;
    end
    chk("stall_extra_txen", n, 0);
    chk("stall_busy", busy, 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("stall_done_idle", busy, 0);
    // back-to-back frames
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) wr(8'(8'h11 * (i + 1)));
    for (int i = 0; i < 3; i++) begin
      wait_txen(20, cyc);
      chk("b2b_din", din, 8'(8'h11 * (i + 1)));
      if (i > 0) chk("b2b_gap", cyc, 2);
      repeat (9) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
    chk("b2b_empty", empty, 1);
    // fill past full while disabled
    do_reset();
    for (int i = 0; i < 17; i++) wr(8'(i + 1));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_txen(20, cyc);
      chk("drain_order", din, 8'(i + 1));
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
    chk("drain_empty", empty, 1);
    // flush with a concurrent write during WAIT
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) wr(8'(8'h40 + i));
    chk("pre_flush_count", count, 5);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_busy", busy, 1);
    chk("flush_din", din, 8'h40);
    repeat (3) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("flush_frame_done", busy, 0);
    n = 0;
    repeat (10) begin
      step();
      if (tx_en) n++;
    end
    chk("post_flush_txen", n, 0);
    // asynchronous reset mid-frame
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'(8'h60 + i));
    chk("pre_rst_count", count, 3);
    chk("pre_rst_busy", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    cmp_model();
    step();
    step();
    rst = 1'b0;
    wr(8'h5A);
    wait_txen(10, cyc);
    chk("post_rst_lat", cyc, 2);
    chk("post_rst_din", din, 8'h5A);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    // pointer wrap with overlapping write and pop
    do_reset();
    enable = 1'b1;
    base = sent.size();
    nxt = 0;
    cyc = 0;
    while (sent.size() - base < 40 && cyc < 3000) begin
      wr_en = (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      wr_data = 8'(nxt);
      tx_done = $urandom_range(0, 1) == 1;
      step();
      cyc++;
      if (wr_en) nxt++;
    end
    wr_en = 1'b0;
    tx_done = 1'b0;
    chk("wrap_frames", sent.size() - base, 40);
    for (int i = 0; i < 40 && base + i < sent.size(); i++) chk("wrap_order", sent[base + i], 8'(i));
    // unconstrained random traffic
    do_reset();
    repeat (1500) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      enable = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 29) == 0;
      ovf_clr = $urandom_range(0, 9) == 0;
      tx_done = $urandom_range(0, 3) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_feeder.md
TX_FEEDER -- requirements
Module: tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..64.
REQ-002 Parameter DW, default 8, data width; matches the TX controller din width.
REQ-003 bclk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 wr_en  in  1  write strobe for wr_data, one entry per cycle.
REQ-006 wr_data  in  DW  byte to transmit.
REQ-007 enable  in  1  permits launching new frames; an in-flight frame always completes.
REQ-008 flush  in  1  discards all queued entries.
REQ-009 ovf_clr  in  1  clears the overflow flag.
REQ-010 tx_done  in  1  one-cycle pulse from the TX controller at end of frame.
REQ-011 tx_en  out  1  one-cycle start pulse to the TX controller.
REQ-012 din  out  DW  frame data; held stable from tx_en until tx_done.
REQ-013 full, empty  out  1 each  FIFO status.
REQ-014 count  out  log2(DEPTH)+1  current number of entries.
REQ-015 overflow  out  1  sticky flag; set by a dropped write.
REQ-016 busy  out  1  high while a frame is launched and not yet done.

Function
REQ-017 The FIFO SHALL be a circular buffer with wrapping read/write pointers; full = (count==DEPTH), empty = (count==0).
REQ-018 A write with full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-019 A simultaneous write (not full) and pop SHALL leave count unchanged and store the new entry.
REQ-020 The FSM SHALL have three states: IDLE, LAUNCH and WAIT.
REQ-021 In IDLE, when enable=1, empty=0 and flush=0, the FSM SHALL pop the head into the din register and go to LAUNCH; otherwise it stays in IDLE.
REQ-022 In LAUNCH, tx_en=1 for exactly one cycle (decoded from the state flop), then the FSM goes to WAIT.
REQ-023 In WAIT, the FSM SHALL go to IDLE on tx_done=1; otherwise it stays in WAIT.
REQ-024 busy SHALL be 1 in LAUNCH and WAIT.
REQ-025 Latency: a write sampled at edge k into an empty FIFO with an idle FSM SHALL give tx_en high between edges k+2 and k+3.
REQ-026 Back-to-back frames: a tx_done at edge m with the FIFO non-empty SHALL give the next tx_en between edges m+2 and m+3.
REQ-027 din SHALL change only on a pop and SHALL hold its last value otherwise.
REQ-028 tx_done outside WAIT SHALL be ignored.
REQ-029 enable deasserted in LAUNCH or WAIT SHALL not abort the frame; it only blocks the next pop.
REQ-030 flush SHALL zero the pointers and count at the next edge, discard a same-cycle write, and block a same-cycle pop; FSM state and din are unaffected.
REQ-031 ovf_clr SHALL clear overflow; if ovf_clr and a dropped write occur together, set wins.

Reset
REQ-032 On rst, the FSM SHALL be in IDLE, with pointers=0, count=0, empty=1, full=0, overflow=0, tx_en=0, busy=0 and din=0.
REQ-033 rst mid-frame SHALL discard the queue and the in-flight frame with no tx_en glitch; the controller is reset by the same rst.

Structure
REQ-034 A shared package uart_pkg SHALL hold the DEPTH/DW defaults and the feeder state encoding (IDLE=0, LAUNCH=1, WAIT=2).
REQ-035 The FIFO SHALL be a sub-module sync_fifo (storage, pointers, count, full/empty); the FSM, din register and overflow SHALL live in tx_feeder.

Verification
REQ-036 Reset, enable=1, write 0xA5 once -> tx_en pulses 2 cycles later, din=0xA5; hold tx_done low 20 cycles -> no further tx_en and busy=1.
REQ-037 Write 0x11, 0x22, 0x33, then return tx_done 10 cycles after each tx_en -> din sequence 0x11, 0x22, 0x33; each tx_en 2 cycles after the prior tx_done; empty=1 at end.
REQ-038 With enable=0, write 17 entries (DEPTH=16) -> full=1, count=16, overflow=1; ovf_clr -> overflow=0; enable=1 -> 16 frames in order.
REQ-039 Queue 5 entries, flush together with a write while in WAIT -> count=0 next cycle, the current frame completes, no further tx_en.
REQ-040 Assert rst in WAIT with 3 entries queued -> all outputs at reset values; after release, a new write is transmitted normally.
REQ-041 Run 40 write/pop cycles so the pointers wrap twice with simultaneous write+pop -> data order preserved and count stays exact.
